fphub_adder_pipe: RTL

//  Pipelined FPHUB adder/subtractor: Z = X + Y (op=0) or X - Y (op=1), HUB format
//  (1.frac plus implicit ILSB=1; rounding to nearest by truncation).

---
 rtl/fphub_pkg.sv | 33 +++
 rtl/fphub_adder_pipe_if.sv | 34 +++
 rtl/fphub_lzd.sv | 24 ++
 rtl/fphub_adder_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fphub_pkg.sv
// Shared definitions for the pipelined FPHUB adder: default widths, derived
// mantissa/count widths and the operand special-case classifier.
package fphub_pkg;

    localparam int FP_M     = 23;
    localparam int FP_E     = 8;
    localparam int FP_GUARD = 7;
    localparam int FP_TAG_W = 4;
    localparam int MW       = FP_M + FP_GUARD + 3;
    localparam int LZW      = $clog2(MW) + 1;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'd0,
        FP_ZERO   = 2'd1,
        FP_INF    = 2'd2,
        FP_NAN    = 2'd3
    } fp_class_e;

    // Any zero exponent counts as zero; all-ones exponent splits on the fraction.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero);
        fp_class_e cls;
        if (exp_zero) begin
            cls = FP_ZERO;
        end else if (exp_ones) begin
            cls = frac_zero ? FP_INF : FP_NAN;
        end else begin
            cls = FP_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fphub_adder_pipe_if.sv
// Operand and result channels of the FPHUB adder pipeline, each with its own
// valid/ready pair. The slave modport is the adder's view.
interface fphub_adder_pipe_if
    import fphub_pkg::*;
#(
    parameter int E     = FP_E,
    parameter int M     = FP_M,
    parameter int TAG_W = FP_TAG_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [E+M:0]     X;
    logic [E+M:0]     Y;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [E+M:0]     Z;
    logic [TAG_W-1:0] tag_out;
    logic             ovf;
    logic             unf;

    modport master (
        output in_valid, op, X, Y, tag_in, out_ready,
        input  in_ready, out_valid, Z, tag_out, ovf, unf
    );

    modport slave (
        input  in_valid, op, X, Y, tag_in, out_ready,
        output in_ready, out_valid, Z, tag_out, ovf, unf
    );

endinterface

// File: rtl/fphub_lzd.sv
// Combinational leading-zero count of a WIDTH-bit vector plus an all-zero flag.
// An all-zero input reports a count of WIDTH.
module fphub_lzd
    import fphub_pkg::*;
#(
    parameter int WIDTH = MW,
    parameter int CNT_W = LZW
) (
    input  logic [WIDTH-1:0] din_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = din_i[i] ? CNT_W'(WIDTH - 1 - i) : cnt_o;
        end
    end

    assign zero_o = ~|din_i;

endmodule

// File: rtl/fphub_adder_pipe.sv
// Three-stage FPHUB adder/subtractor (align, add, normalise) with a single
// global stall: every stage holds while a result waits at the output.
module fphub_adder_pipe
    import fphub_pkg::*;
#(
    parameter int M     = FP_M,
    parameter int E     = FP_E,
    parameter int GUARD = FP_GUARD,
    parameter int TAG_W = FP_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    fphub_adder_pipe_if.slave bus
);

    localparam int W      = E + M + 1;
    localparam int MANT_W = M + GUARD + 3;
    localparam int CNT_W  = $clog2(MANT_W) + 1;
    localparam int CW     = E + CNT_W;
    localparam logic [E-1:0] EXP_ONES = {E{1'b1}};
    localparam logic [E-1:0] EXP_MAXN = {{(E-1){1'b1}}, 1'b0};
    localparam logic [E-1:0] EXP_ONE  = {{(E-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] NAN_WORD = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic adv_s;

    logic            x_sgn_s, y_sgn_s;
    logic [E-1:0]    x_exp_s, y_exp_s, min_exp_s, exp_diff_s;
    logic [M-1:0]    x_frac_s, y_frac_s, maj_frac_s, min_frac_s;
    fp_class_e       x_cls_s, y_cls_s;
    logic            x_major_s, min_sgn_s;
    logic [MANT_W-1:0] min_full_s;

    logic              spec_d, sign_d, eff_sub_d;
    logic [W-1:0]      spec_z_d;
    logic [E-1:0]      exp_d;
    logic [MANT_W-1:0] maj_d, min_d;

    logic              s1_valid_q, s1_spec_q, s1_sign_q, s1_eff_sub_q;
    logic [W-1:0]      s1_spec_z_q;
    logic [E-1:0]      s1_exp_q;
    logic [MANT_W-1:0] s1_maj_q, s1_min_q;
    logic [TAG_W-1:0]  s1_tag_q;

    logic [MANT_W-1:0] sum_d;
    logic              s2_valid_q, s2_spec_q, s2_sign_q, s2_eff_sub_q;
    logic [W-1:0]      s2_spec_z_q;
    logic [E-1:0]      s2_exp_q;
    logic [MANT_W-1:0] s2_sum_q;
    logic [TAG_W-1:0]  s2_tag_q;

    logic [CNT_W-1:0] lz_cnt_s;
    logic             lz_zero_s;
    logic [CW-1:0]    shamt_s;
    logic [W-1:0]     z_d;
    logic             ovf_d, unf_d;

    logic             out_valid_q, ovf_q, unf_q;
    logic [W-1:0]     z_q;
    logic [TAG_W-1:0] tag_q;

    assign adv_s        = ~(out_valid_q & ~bus.out_ready);
    assign bus.in_ready = adv_s;

    // Subtraction is folded into Y's sign on entry.
    assign x_sgn_s  = bus.X[W-1];
    assign x_exp_s  = bus.X[W-2:M];
    assign x_frac_s = bus.X[M-1:0];
    assign y_sgn_s  = bus.Y[W-1] ^ bus.op;
    assign y_exp_s  = bus.Y[W-2:M];
    assign y_frac_s = bus.Y[M-1:0];
    assign x_cls_s  = classify(~|x_exp_s, &x_exp_s, ~|x_frac_s);
    assign y_cls_s  = classify(~|y_exp_s, &y_exp_s, ~|y_frac_s);

    // S1: special-case resolution and alignment of the minor operand.
    always_comb begin
        spec_d   = 1'b1;
        spec_z_d = '0;
        if (x_cls_s == FP_NAN || y_cls_s == FP_NAN) begin
            spec_z_d = NAN_WORD;
        end else if (x_cls_s == FP_INF && y_cls_s == FP_INF) begin
            spec_z_d = (x_sgn_s == y_sgn_s) ? {x_sgn_s, EXP_ONES, {M{1'b0}}} : NAN_WORD;
        end else if (x_cls_s == FP_INF) begin
            spec_z_d = {x_sgn_s, EXP_ONES, {M{1'b0}}};
        end else if (y_cls_s == FP_INF) begin
            spec_z_d = {y_sgn_s, EXP_ONES, {M{1'b0}}};
        end else if (x_cls_s == FP_ZERO && y_cls_s == FP_ZERO) begin
            spec_z_d = {x_sgn_s & y_sgn_s, {(W-1){1'b0}}};
        end else if (x_cls_s == FP_ZERO) begin
            spec_z_d = {y_sgn_s, y_exp_s, y_frac_s};
        end else if (y_cls_s == FP_ZERO) begin
            spec_z_d = {x_sgn_s, x_exp_s, x_frac_s};
        end else begin
            spec_d = 1'b0;
        end

        x_major_s  = {x_exp_s, x_frac_s} >= {y_exp_s, y_frac_s};
        sign_d     = x_major_s ? x_sgn_s  : y_sgn_s;
        min_sgn_s  = x_major_s ? y_sgn_s  : x_sgn_s;
        exp_d      = x_major_s ? x_exp_s  : y_exp_s;
        min_exp_s  = x_major_s ? y_exp_s  : x_exp_s;
        maj_frac_s = x_major_s ? x_frac_s : y_frac_s;
        min_frac_s = x_major_s ? y_frac_s : x_frac_s;
        exp_diff_s = exp_d - min_exp_s;
        eff_sub_d  = sign_d ^ min_sgn_s;
        maj_d      = {1'b0, 1'b1, maj_frac_s, 1'b1, {GUARD{1'b0}}};
        min_full_s = {1'b0, 1'b1, min_frac_s, 1'b1, {GUARD{1'b0}}};
        if (int'(exp_diff_s) >= MANT_W) begin
            min_d = '0;
        end else begin
            min_d = min_full_s >> exp_diff_s;
        end
    end

    // S1 register set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_spec_q    <= 1'b0;
            s1_spec_z_q  <= '0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_eff_sub_q <= 1'b0;
            s1_maj_q     <= '0;
            s1_min_q     <= '0;
            s1_tag_q     <= '0;
        end else if (adv_s) begin
            s1_valid_q   <= bus.in_valid;
            s1_spec_q    <= spec_d;
            s1_spec_z_q  <= spec_z_d;
            s1_sign_q    <= sign_d;
            s1_exp_q     <= exp_d;
            s1_eff_sub_q <= eff_sub_d;
            s1_maj_q     <= maj_d;
            s1_min_q     <= min_d;
            s1_tag_q     <= bus.tag_in;
        end
    end

    // The major magnitude is never smaller than the aligned minor, so no sign flip.
    assign sum_d = s1_eff_sub_q ? (s1_maj_q - s1_min_q) : (s1_maj_q + s1_min_q);

    // S2 register set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_spec_q    <= 1'b0;
            s2_spec_z_q  <= '0;
            s2_sign_q    <= 1'b0;
            s2_exp_q     <= '0;
            s2_eff_sub_q <= 1'b0;
            s2_sum_q     <= '0;
            s2_tag_q     <= '0;
        end else if (adv_s) begin
            s2_valid_q   <= s1_valid_q;
            s2_spec_q    <= s1_spec_q;
            s2_spec_z_q  <= s1_spec_z_q;
            s2_sign_q    <= s1_sign_q;
            s2_exp_q     <= s1_exp_q;
            s2_eff_sub_q <= s1_eff_sub_q;
            s2_sum_q     <= sum_d;
            s2_tag_q     <= s1_tag_q;
        end
    end

    fphub_lzd #(
        .WIDTH (MANT_W),
        .CNT_W (CNT_W)
    ) u_lzd (
        .din_i  (s2_sum_q),
        .cnt_o  (lz_cnt_s),
        .zero_o (lz_zero_s)
    );

    // S3: normalise; the count includes the always-clear top bit, hence the -1.
    always_comb begin
        z_d     = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        shamt_s = CW'(lz_cnt_s) - CW'(1'b1);
        if (s2_spec_q) begin
            z_d = s2_spec_z_q;
        end else if (!s2_eff_sub_q) begin
            if (!s2_sum_q[MANT_W-1]) begin
                z_d = {s2_sign_q, s2_exp_q, M'(s2_sum_q >> (GUARD + 1))};
            end else if (s2_exp_q == EXP_MAXN) begin
                z_d   = {s2_sign_q, EXP_ONES, {M{1'b0}}};
                ovf_d = 1'b1;
            end else begin
                z_d = {s2_sign_q, s2_exp_q + EXP_ONE, M'(s2_sum_q >> (GUARD + 2))};
            end
        end else if (lz_zero_s) begin
            z_d = '0;
        end else if (shamt_s >= CW'(s2_exp_q)) begin
            z_d   = {s2_sign_q, {(W-1){1'b0}}};
            unf_d = 1'b1;
        end else begin
            z_d = {s2_sign_q, s2_exp_q - E'(shamt_s),
                   M'((s2_sum_q << shamt_s) >> (GUARD + 1))};
        end
    end

    // Output register set; data only reloads with a valid result so bubbles leave Z alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            tag_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (adv_s) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                z_q   <= z_d;
                tag_q <= s2_tag_q;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.Z         = z_q;
    assign bus.tag_out   = tag_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule
